// File: rtl/tp_sequencer.sv
// Frame-synchronous playlist scheduler for the test-pattern generator; config changes land on VS start only.
// Optional backward stepping (I_prev port) is enabled by defining TP_SEQ_PREV_EN.
module tp_sequencer #(
   parameter int unsigned DWELL_FRAMES = 120,
   parameter int unsigned SQR_W_SMALL  = 16,
   parameter int unsigned SQR_W_LARGE  = 64
) (
   input  logic        I_pxl_clk,
   input  logic        I_rst,
   input  logic        I_vs,
   input  logic        I_vs_pol,
   input  logic        I_auto_en,
   input  logic        I_hold,
   input  logic        I_step,
`ifdef TP_SEQ_PREV_EN
   input  logic        I_prev,
`endif
   output logic [2:0]  O_mode,
   output logic [15:0] O_sqr_width,
   output logic [7:0]  O_single_r,
   output logic [7:0]  O_single_g,
   output logic [7:0]  O_single_b,
   output logic [2:0]  O_seq_idx,
   output logic [15:0] O_frame_cnt,
   output logic        O_update
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);

   state_t      state, state_n;
   logic        vs_act, vs_act_d, fs;
   logic [15:0] dwell, dwell_n;
   logic [2:0]  idx, idx_n;
   logic        pend_bwd, pend_bwd_n;
   logic        req_fwd, req_bwd, req;
   logic        adv, adv_bwd, auto_ok;
   logic [2:0]  mode_n;
   logic [15:0] sqr_n;
   logic [7:0]  r_n, g_n, b_n;

   assign vs_act  = I_vs_pol ? I_vs : ~I_vs;
   assign fs      = vs_act & ~vs_act_d;
   assign auto_ok = I_auto_en & ~I_hold;

   // Simultaneous forward and backward requests cancel each other out.
`ifdef TP_SEQ_PREV_EN
   assign req_fwd = I_step & ~I_prev;
   assign req_bwd = I_prev & ~I_step;
`else
   assign req_fwd = I_step;
   assign req_bwd = 1'b0;
`endif
   assign req = req_fwd | req_bwd;

   always_comb begin
      state_n    = state;
      dwell_n    = dwell;
      idx_n      = idx;
      pend_bwd_n = pend_bwd;
      adv        = 1'b0;
      adv_bwd    = 1'b0;
      case (state)
         ST_IDLE: if (fs) state_n = ST_RUN;
         ST_RUN: begin
            // A step request on fs takes priority over auto expiry, so both together give one step.
            if (fs) begin
               if (req) begin
                  adv     = 1'b1;
                  adv_bwd = req_bwd;
               end else if (auto_ok) begin
                  if (dwell == DWELL_LAST) adv = 1'b1;
                  else dwell_n = dwell + 16'd1;
               end
            end else if (req) begin
               state_n    = ST_PEND;
               pend_bwd_n = req_bwd;
            end
         end
         ST_PEND: begin
            if (req) pend_bwd_n = req_bwd;
            if (fs) begin
               adv     = 1'b1;
               adv_bwd = pend_bwd_n;
               state_n = ST_RUN;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (adv) begin
         idx_n   = adv_bwd ? idx - 3'd1 : idx + 3'd1;
         dwell_n = '0;
      end
      if (!I_auto_en) dwell_n = '0;
   end

   always_comb begin
      mode_n = 3'b000;
      sqr_n  = 16'(SQR_W_SMALL);
      r_n    = '0;
      g_n    = '0;
      b_n    = '0;
      case (idx_n)
         3'd0: mode_n = 3'b000;
         3'd1: mode_n = 3'b001;
         3'd2: mode_n = 3'b010;
         3'd3: mode_n = 3'b011;
         3'd4: begin mode_n = 3'b011; sqr_n = 16'(SQR_W_LARGE); end
         3'd5: begin mode_n = 3'b111; r_n = '1; end
         3'd6: begin mode_n = 3'b111; g_n = '1; end
         default: begin mode_n = 3'b111; b_n = '1; end
      endcase
   end

   always_ff @(posedge I_pxl_clk) begin
      if (I_rst) begin
         state       <= ST_IDLE;
         vs_act_d    <= 1'b1;
         dwell       <= '0;
         idx         <= '0;
         pend_bwd    <= 1'b0;
         O_mode      <= 3'b000;
         O_sqr_width <= 16'(SQR_W_SMALL);
         O_single_r  <= '0;
         O_single_g  <= '0;
         O_single_b  <= '0;
         O_seq_idx   <= '0;
         O_frame_cnt <= '0;
         O_update    <= 1'b0;
      end else begin
         state       <= state_n;
         vs_act_d    <= vs_act;
         dwell       <= dwell_n;
         idx         <= idx_n;
         pend_bwd    <= pend_bwd_n;
         O_mode      <= mode_n;
         O_sqr_width <= sqr_n;
         O_single_r  <= r_n;
         O_single_g  <= g_n;
         O_single_b  <= b_n;
         O_seq_idx   <= idx_n;
         O_update    <= adv;
         if (fs) O_frame_cnt <= O_frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_tp_sequencer.sv
// Directed self-checking bench for tp_sequencer with DWELL_FRAMES=3.
// Backward-step scenarios are compiled in when TP_SEQ_PREV_EN is defined.
module tb_tp_sequencer;

   logic        clk = 1'b0;
   logic        rst, vs, vs_pol, auto_en, hold, step;
`ifdef TP_SEQ_PREV_EN
   logic        prev;
`endif
   logic [2:0]  mode, seq_idx;
   logic [15:0] sqr_width, frame_cnt;
   logic [7:0]  single_r, single_g, single_b;
   logic        update;
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [2:0]  exp_idx [10];
   logic [2:0]  last_idx;

   always #5 clk = ~clk;

   tp_sequencer #(.DWELL_FRAMES(3), .SQR_W_SMALL(16), .SQR_W_LARGE(64)) dut (
      .I_pxl_clk(clk), .I_rst(rst), .I_vs(vs), .I_vs_pol(vs_pol),
      .I_auto_en(auto_en), .I_hold(hold), .I_step(step),
`ifdef TP_SEQ_PREV_EN
      .I_prev(prev),
`endif
      .O_mode(mode), .O_sqr_width(sqr_width), .O_single_r(single_r),
      .O_single_g(single_g), .O_single_b(single_b), .O_seq_idx(seq_idx),
      .O_frame_cnt(frame_cnt), .O_update(update)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rise();
      vs = vs_pol;
      tick();
   endtask

   task automatic fall();
      vs = ~vs_pol;
      tick();
      tick();
   endtask

   task automatic chk_cfg(input string tag, input logic [2:0] i, input logic [2:0] m,
                          input logic [15:0] w, input logic [23:0] rgb);
      chk({tag, "_idx"}, 32'(seq_idx), 32'(i));
      chk({tag, "_mode"}, 32'(mode), 32'(m));
      chk({tag, "_sqr"}, 32'(sqr_width), 32'(w));
      chk({tag, "_rgb"}, {8'd0, single_r, single_g, single_b}, 32'(rgb));
   endtask

   initial begin
      exp_idx = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
      rst = 1'b1; vs = 1'b1; vs_pol = 1'b1; auto_en = 1'b1; hold = 1'b0; step = 1'b0;
`ifdef TP_SEQ_PREV_EN
      prev = 1'b0;
`endif
      tick(); tick();
      rst = 1'b0;
      tick();
      chk_cfg("reset", 3'd0, 3'b000, 16'd16, 24'h000000);
      chk("reset_fcnt", 32'(frame_cnt), 32'd0);
      chk("reset_upd", 32'(update), 32'd0);
      tick(); tick();
      chk("vs_active_at_reset_fcnt", 32'(frame_cnt), 32'd0);
      chk("vs_active_at_reset_upd", 32'(update), 32'd0);

      // Step in IDLE must be discarded.
      step = 1'b1; tick(); step = 1'b0;
      fall();

      last_idx = 3'd0;
      for (int k = 0; k < 10; k++) begin
         rise();
         chk($sformatf("auto_idx_%0d", k), 32'(seq_idx), 32'(exp_idx[k]));
         chk($sformatf("auto_upd_%0d", k), 32'(update), 32'(exp_idx[k] != last_idx));
         tick();
         chk($sformatf("auto_upd_end_%0d", k), 32'(update), 32'd0);
         last_idx = exp_idx[k];
         fall();
      end
      chk("auto_fcnt", 32'(frame_cnt), 32'd10);
      chk_cfg("auto_idx3", 3'd3, 3'b011, 16'd16, 24'h000000);

      // Manual stepping with auto off: 3 -> 4 -> 5, second request in PEND ignored.
      auto_en = 1'b0; tick();
      step = 1'b1; tick(); step = 1'b0; tick();
      chk_cfg("pend3", 3'd3, 3'b011, 16'd16, 24'h000000);
      chk("pend3_upd", 32'(update), 32'd0);
      rise();
      chk_cfg("step4", 3'd4, 3'b011, 16'd64, 24'h000000);
      chk("step4_upd", 32'(update), 32'd1);
      fall();
      step = 1'b1; tick(); step = 1'b0; tick();
      chk_cfg("pend4", 3'd4, 3'b011, 16'd64, 24'h000000);
      step = 1'b1; tick(); step = 1'b0; tick();
      rise();
      chk_cfg("step5", 3'd5, 3'b111, 16'd16, 24'hFF0000);
      chk("step5_upd", 32'(update), 32'd1);
      fall();
      rise();
      chk("no_accum_idx", 32'(seq_idx), 32'd5);
      chk("no_accum_upd", 32'(update), 32'd0);
      fall();
      chk("manual_fcnt", 32'(frame_cnt), 32'd13);

      // Step coincident with frame start.
      step = 1'b1; rise(); step = 1'b0;
      chk("coin6_idx", 32'(seq_idx), 32'd6);
      chk("coin6_rgb", {8'd0, single_r, single_g, single_b}, 32'h0000FF00);
      chk("coin6_upd", 32'(update), 32'd1);
      fall();
      step = 1'b1; rise(); step = 1'b0;
      chk_cfg("coin7", 3'd7, 3'b111, 16'd16, 24'h0000FF);
      fall();
      auto_en = 1'b1;
      rise(); fall();
      rise(); fall();
      chk("dwell2_idx7", 32'(seq_idx), 32'd7);
      step = 1'b1; rise(); step = 1'b0;
      chk_cfg("wrap0", 3'd0, 3'b000, 16'd16, 24'h000000);
      chk("wrap0_upd", 32'(update), 32'd1);
      tick();
      chk("wrap0_upd_end", 32'(update), 32'd0);
      fall();
      chk("coin_fcnt", 32'(frame_cnt), 32'd18);

      // Hold at dwell 2 blocks advance for 5 frames.
      rise(); fall();
      rise(); fall();
      hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         rise();
         chk($sformatf("hold_idx_%0d", k), 32'(seq_idx), 32'd0);
         chk($sformatf("hold_upd_%0d", k), 32'(update), 32'd0);
         fall();
      end
      hold = 1'b0;
      rise();
      chk("release_idx", 32'(seq_idx), 32'd1);
      chk("release_upd", 32'(update), 32'd1);
      fall();
      chk("hold_fcnt", 32'(frame_cnt), 32'd26);

      // Negative VS polarity: falling I_vs is the frame start.
      vs = 1'b1; vs_pol = 1'b0;
      tick(); tick();
      chk("pol_switch_fcnt", 32'(frame_cnt), 32'd26);
      rise();
      chk("neg_fs_fcnt", 32'(frame_cnt), 32'd27);
      fall();
      chk("neg_rise_no_fs", 32'(frame_cnt), 32'd27);
      rise(); fall();
      rise();
      chk_cfg("neg_adv", 3'd2, 3'b010, 16'd16, 24'h000000);
      fall();
      chk("neg_fcnt", 32'(frame_cnt), 32'd29);

      // Reset mid-operation drops a pending step.
      auto_en = 1'b0;
      step = 1'b1; tick(); step = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      chk_cfg("midrst", 3'd0, 3'b000, 16'd16, 24'h000000);
      chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
      rise();
      chk("midrst_idle_idx", 32'(seq_idx), 32'd0);
      chk("midrst_fcnt1", 32'(frame_cnt), 32'd1);
      fall();
      rise();
      chk("midrst_lost_idx", 32'(seq_idx), 32'd0);
      chk("midrst_lost_upd", 32'(update), 32'd0);
      fall();

`ifdef TP_SEQ_PREV_EN
      prev = 1'b1; tick(); prev = 1'b0; tick();
      rise();
      chk_cfg("prev7", 3'd7, 3'b111, 16'd16, 24'h0000FF);
      fall();
      step = 1'b1; prev = 1'b1; rise(); step = 1'b0; prev = 1'b0;
      chk("both_idx", 32'(seq_idx), 32'd7);
      chk("both_upd", 32'(update), 32'd0);
      fall();
      step = 1'b1; tick(); step = 1'b0;
      prev = 1'b1; tick(); prev = 1'b0;
      rise();
      chk("last_dir_idx", 32'(seq_idx), 32'd6);
      fall();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tp_sequencer.md
# tp_sequencer

Frame-synchronous scheduler for the test-pattern generator. It drives the generator's pattern-select and pattern-configuration inputs, and steps through a fixed 8-entry pattern playlist, either automatically after a programmable number of frames or on a manual step request. All configuration changes are applied only at the start of the vertical sync pulse, so no frame ever mixes two patterns. It sits between board-level controls (buttons, auto/hold switches) and the generator, in the pixel-clock domain.

## Interface
Parameters:
- DWELL_FRAMES, 120: frames each entry is shown in auto mode; legal range 1..65535.
- SQR_W_SMALL, 16: square width for playlist entry 3.
- SQR_W_LARGE, 64: square width for playlist entry 4.

Ports:
- I_pxl_clk  in  1  pixel clock; the only clock.
- I_rst  in  1  reset, synchronous, active-high.
- I_vs  in  1  VS from the generator's output, at the generator's polarity.
- I_vs_pol  in  1  VS polarity: 1 = positive, 0 = negative.
- I_auto_en  in  1  enables auto advance.
- I_hold  in  1  freezes the dwell counter and blocks auto advance.
- I_step  in  1  single-cycle pulse requesting one forward step.
- O_mode  out  3  pattern select to the generator.
- O_sqr_width  out  16  square width to the generator.
- O_single_r / O_single_g / O_single_b  out  8 each  single-colour value.
- O_seq_idx  out  3  current playlist index.
- O_frame_cnt  out  16  free-running frame counter.
- O_update  out  1  one-cycle pulse, high in the first cycle new config is visible.

## Operation
- Active VS: vs_act = I_vs_pol ? I_vs : ~I_vs. This signal is registered into vs_act_d.
- Frame start (fs): vs_act & ~vs_act_d.
- vs_act_d resets to 1, so a VS that is already active at reset does not produce fs.
- Playlist, listed as idx: mode / sqr_width / single R,G,B. Any field not listed holds the default: sqr_width = SQR_W_SMALL, single = 0.
  - 0: 000 colour bar
  - 1: 001 net grid
  - 2: 010 gray
  - 3: 011 square, SQR_W_SMALL
  - 4: 011 square, SQR_W_LARGE
  - 5: 111 single, 255,0,0
  - 6: 111 single, 0,255,0
  - 7: 111 single, 0,0,255
- The index wraps from 7 to 0. All outputs are registered and decoded from the index.
- States:
  - IDLE, entered from reset: no advance occurs and step requests are discarded. The first fs moves to RUN.
  - RUN, dwell counter 16 bits:
    - The counter increments on each fs while I_auto_en=1 and I_hold=0.
    - It is held while I_hold=1, and cleared while I_auto_en=0.
    - Auto advance: fs with the counter at DWELL_FRAMES-1 and auto enabled and not held. The index increments and the counter clears.
    - I_step without fs moves to PEND.
    - I_step coincident with fs advances immediately and stays in RUN.
  - PEND: the next fs advances one index, clears the dwell counter, and returns to RUN. Further I_step pulses in PEND are ignored; they do not accumulate.
- An auto advance and a step advance on the same fs produce a single step, not two.
- O_frame_cnt increments on every fs in every state and wraps from 65535 to 0.

## Timing
- Reset values:
  - O_mode=000, O_sqr_width=SQR_W_SMALL, single=0,0,0, O_seq_idx=0.
  - O_frame_cnt=0, O_update=0, dwell=0, state IDLE.
- Reset asserted mid-operation overrides everything on the next edge; a pending step is lost.
- Latency: fs is combinational in cycle t, when I_vs first shows active. New outputs and O_update=1 appear in cycle t+1. O_update returns to 0 in t+2.
- O_update pulses only when the index actually changes.
- O_frame_cnt updates on the same edge as the config.

## Configuration
- TP_SEQ_PREV_EN defined:
  - Adds input I_prev (1 bit, single-cycle pulse): one backward step, wrapping from 0 to 7.
  - I_prev follows the same pending and frame-start rules as I_step.
  - In PEND, the last accepted request sets the direction.
  - I_step and I_prev in the same cycle are both ignored.
- TP_SEQ_PREV_EN not defined: no I_prev port; stepping is forward-only.

## Test plan
All scenarios use DWELL_FRAMES=3.
- Reset with I_vs active (pol=1, I_vs=1), then hold -> no fs; O_mode=000, O_update stays 0, state stays IDLE until I_vs falls and rises again.
- Auto on, 10 frame starts -> O_seq_idx after each fs: 0,0,0,1,1,1,2,2,2,3. O_frame_cnt=10. Each O_update pulse is one cycle long, one cycle after VS rises.
- I_step pulsed mid-frame at idx 4, auto off -> outputs unchanged until the next fs. Then idx=5, O_mode=111, single=255,0,0. A second I_step in PEND does not move beyond 5.
- I_step coincident with fs at idx 7 -> idx=0, O_mode=000, O_sqr_width=16 in the next cycle. A coincident auto expiry in the same cycle still yields a single step.
- I_hold=1 for 5 frames at dwell=2 -> no advance. After release, the next fs advances. With pol=0, the VS falling edge is the frame start.
- With TP_SEQ_PREV_EN, I_prev at idx 0 -> idx=7 after fs, O_mode=111, single=0,0,255. I_step and I_prev together -> no change.
